// File: rtl/load_store_align.sv
// Memory-access stage: alignment check, byte-lane steering and req/ack sequencing
// toward a variable-latency data memory. Optional ack timeout: define LSU_TIMEOUT_EN.
module load_store_align #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              ld_valid,
    output logic [31:0]       ld_data,
    output logic [2:0]        ld_type,
    output logic              st_done,
    output logic              misalign_err
`ifdef LSU_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic        accept;
    logic        reject;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;

    // Elaboration-time guard: a sub-2 limit would make the timeout fire on entry.
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;
`endif

    assign accept = req_valid & req_ready;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        reject     = 1'b0;
        be_next    = 4'b1111;
        wdata_next = req_wdata;
        case (req_funct3)
            3'b000, 3'b100: reject = 1'b0;
            3'b001, 3'b101: reject = req_addr[0];
            3'b010:         reject = (req_addr[1:0] != 2'b00);
            default:        reject = 1'b1;
        endcase
        if (req_we && req_funct3[2]) begin
            reject = 1'b1;
        end
        // Replicating the datum puts it in the enabled lanes for every offset.
        case (req_funct3[1:0])
            2'b00: begin
                be_next    = 4'b0001 << req_addr[1:0];
                wdata_next = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_next    = 4'b0011 << req_addr[1:0];
                wdata_next = {2{req_wdata[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = req_wdata;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            req_ready    <= 1'b0;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            off_q        <= 2'b00;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_be       <= 4'b0000;
            mem_addr     <= '0;
            mem_wdata    <= 32'h0;
            ld_valid     <= 1'b0;
            ld_data      <= 32'h0;
            ld_type      <= 3'b000;
            st_done      <= 1'b0;
            misalign_err <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            timeout_err  <= 1'b0;
            wait_cnt     <= '0;
`endif
        end else begin
            ld_valid     <= 1'b0;
            st_done      <= 1'b0;
            misalign_err <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            timeout_err  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        we_q      <= req_we;
                        funct3_q  <= req_funct3;
                        off_q     <= req_addr[1:0];
                        if (reject) begin
                            misalign_err <= 1'b1;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_be    <= be_next;
                            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem_wdata <= wdata_next;
                            state     <= WAIT;
`ifdef LSU_TIMEOUT_EN
                            wait_cnt  <= '0;
`endif
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= DONE;
                        if (we_q) begin
                            st_done <= 1'b1;
                        end else begin
                            ld_valid <= 1'b1;
                            ld_data  <= mem_rdata >> {off_q, 3'b000};
                            ld_type  <= funct3_q;
                        end
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        mem_req     <= 1'b0;
                        timeout_err <= 1'b1;
                        req_ready   <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_align.sv
// Scoreboard bench for load_store_align: directed requests push expected events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_load_store_align;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic [2:0]  ld_type;
    logic        st_done;
    logic        misalign_err;
`ifdef LSU_TIMEOUT_EN
    logic        timeout_err;
    localparam int TO_CYC = 8;
`else
    localparam int TO_CYC = 64;
`endif

    always #5 clk = ~clk;

    load_store_align #(.ADDR_W(32), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_type(ld_type),
        .st_done(st_done), .misalign_err(misalign_err)
`ifdef LSU_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    typedef enum int {EV_MEM, EV_LD, EV_ST, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] data;
        logic [2:0]  typ;
    } ev_t;

    ev_t sb[$];
    int  vectors = 0;
    int  miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pop_expect(input ev_kind_t k, output ev_t e, output bit ok);
        ok = 1'b0;
        e  = '{EV_ERR, 32'h0, 4'h0, 1'b0, 32'h0, 3'h0};
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: got kind %0d, expected none at %0t", k, $time);
        end else begin
            e  = sb.pop_front();
            check("event_kind", e.kind, k);
            ok = (e.kind == k);
        end
    endtask

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    initial begin
        logic        prev_req;
        logic [31:0] prev_addr, prev_wdata;
        logic [4:0]  prev_bewe;
        logic [31:0] mask;
        ev_t         e;
        bit          ok;
        prev_req = 1'b0;
        prev_addr = 32'h0;
        prev_wdata = 32'h0;
        prev_bewe = 5'h0;
        forever begin
            @(negedge clk);
            if (mem_req && !prev_req) begin
                pop_expect(EV_MEM, e, ok);
                if (ok) begin
                    check("mem_addr", mem_addr, e.addr);
                    check("mem_be_we", {mem_be, mem_we}, {e.be, e.we});
                    if (e.we) begin
                        mask = {{8{e.be[3]}}, {8{e.be[2]}}, {8{e.be[1]}}, {8{e.be[0]}}};
                        check("mem_wdata", mem_wdata & mask, e.data & mask);
                    end
                end
            end else if (mem_req && prev_req) begin
                check("hold_addr", mem_addr, prev_addr);
                check("hold_be_we", {mem_be, mem_we}, prev_bewe);
                check("hold_wdata", mem_wdata, prev_wdata);
            end
            if (ld_valid) begin
                pop_expect(EV_LD, e, ok);
                if (ok) begin
                    check("ld_data", ld_data, e.data);
                    check("ld_type", ld_type, e.typ);
                end
            end
            if (st_done) pop_expect(EV_ST, e, ok);
            if (misalign_err) pop_expect(EV_ERR, e, ok);
            prev_req   = mem_req;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
            prev_bewe  = {mem_be, mem_we};
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("req_ready_wait", req_ready, 1'b1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_mem_ack(input logic [31:0] rdata, input int delay);
        int n = 0;
        @(negedge clk);
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!mem_req) begin
            check("mem_req_wait", mem_req, 1'b1);
        end else begin
            repeat (delay) @(negedge clk);
            mem_ack   = 1'b1;
            mem_rdata = rdata;
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
        end
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                           input int delay, input logic [3:0] be, input logic [31:0] exp_data);
        sb.push_back('{EV_MEM, addr & 32'hFFFF_FFFC, be, 1'b0, 32'h0, 3'h0});
        sb.push_back('{EV_LD, 32'h0, 4'h0, 1'b0, exp_data, f3});
        issue(1'b0, f3, addr, 32'h0);
        wait_mem_ack(rdata, delay);
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                            input int delay, input logic [3:0] be, input logic [31:0] exp_wdata);
        sb.push_back('{EV_MEM, addr & 32'hFFFF_FFFC, be, 1'b1, exp_wdata, 3'h0});
        sb.push_back('{EV_ST, 32'h0, 4'h0, 1'b0, 32'h0, 3'h0});
        issue(1'b1, f3, addr, wdata);
        wait_mem_ack(32'h0, delay);
    endtask

    task automatic do_bad(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        sb.push_back('{EV_ERR, 32'h0, 4'h0, 1'b0, 32'h0, 3'h0});
        issue(we, f3, addr, 32'h1234_5678);
        @(negedge clk);
        check("ready_in_err_cycle", req_ready, 1'b0);
        @(negedge clk);
        check("ready_after_err", req_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #12;
        check("rst_ctrl", {28'h0, req_ready, mem_req, ld_valid, st_done}, 32'h0);
        check("rst_err_be", {27'h0, misalign_err, mem_be}, 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_ld", {ld_type, ld_data[28:0]}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", req_ready, 1'b1);

        do_load(3'b010, 32'h100, 32'hDEADBEEF, 2, 4'b1111, 32'hDEADBEEF);
        do_load(3'b100, 32'h103, 32'h80112233, 0, 4'b1000, 32'h0000_0080);
        do_load(3'b000, 32'h101, 32'h11223344, 1, 4'b0010, 32'h0011_2233);
        do_load(3'b001, 32'h002, 32'hA1B2C3D4, 0, 4'b1100, 32'h0000_A1B2);
        do_load(3'b101, 32'h000, 32'hCAFEF00D, 0, 4'b0011, 32'hCAFEF00D);
        do_store(3'b001, 32'h202, 32'h0000ABCD, 1, 4'b1100, 32'hABCD_0000);
        do_store(3'b000, 32'h003, 32'h0000005A, 0, 4'b1000, 32'h5A00_0000);
        do_store(3'b000, 32'h201, 32'hFFFFFF77, 2, 4'b0010, 32'h0000_7700);
        do_store(3'b010, 32'h300, 32'h12345678, 3, 4'b1111, 32'h1234_5678);

        do_bad(1'b0, 3'b010, 32'h101);
        do_bad(1'b0, 3'b001, 32'h003);
        do_bad(1'b0, 3'b011, 32'h000);
        do_bad(1'b1, 3'b100, 32'h010);
        do_bad(1'b0, 3'b110, 32'h020);
        do_bad(1'b1, 3'b010, 32'h302);

        // Stray ack while idle must produce nothing.
        @(negedge clk);
        mem_ack = 1'b1;
        mem_rdata = 32'h5555_5555;
        @(negedge clk);
        mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("ready_after_stray_ack", req_ready, 1'b1);

        // Reset in the middle of WAIT, then a late ack after release.
        sb.push_back('{EV_MEM, 32'h400, 4'b1111, 1'b0, 32'h0, 3'h0});
        issue(1'b0, 3'b010, 32'h400, 32'h0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_wait_req", mem_req, 1'b0);
        check("rst_mid_wait_ready", req_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'h7777_7777;
        @(negedge clk);
        mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_wait_ld_data", ld_data, 32'h0);
        check("ready_after_mid_reset", req_ready, 1'b1);
        do_load(3'b010, 32'h404, 32'h0F0F_0F0F, 0, 4'b1111, 32'h0F0F_0F0F);

`ifdef LSU_TIMEOUT_EN
        sb.push_back('{EV_MEM, 32'h500, 4'b1111, 1'b0, 32'h0, 3'h0});
        issue(1'b0, 3'b010, 32'h500, 32'h0);
        @(negedge clk);
        check("to_mem_req", mem_req, 1'b1);
        n = 0;
        while (!timeout_err && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("timeout_delay", n, TO_CYC);
        check("timeout_mem_req", mem_req, 1'b0);
        @(negedge clk);
        check("timeout_pulse_len", timeout_err, 1'b0);
        do_load(3'b000, 32'h502, 32'hAABBCCDD, 0, 4'b0100, 32'h0000_AABB);
`endif

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
